// File: rtl/alu_pkg.sv
// Shared opcode encoding for the ProtoCore ALU.
package alu_pkg;

  localparam int OPCODE_W = 3;

  localparam logic [OPCODE_W-1:0] OP_ADD = 3'b000;
  localparam logic [OPCODE_W-1:0] OP_SUB = 3'b001;
  localparam logic [OPCODE_W-1:0] OP_AND = 3'b010;
  localparam logic [OPCODE_W-1:0] OP_OR  = 3'b011;
  localparam logic [OPCODE_W-1:0] OP_XOR = 3'b100;
  localparam logic [OPCODE_W-1:0] OP_NOT = 3'b101;
  localparam logic [OPCODE_W-1:0] OP_SHL = 3'b110;
  localparam logic [OPCODE_W-1:0] OP_SHR = 3'b111;

endpackage

// File: rtl/alu_flags_reg.sv
// Status-flag register: captures carry/zero on write enable.
module alu_flags_reg (
  input  logic clk,
  input  logic rst,
  input  logic we_i,
  input  logic carry_i,
  input  logic zero_i,
  output logic carry_o,
  output logic zero_o
);

  logic [1:0] flags_q;
  logic [1:0] flags_d;

  always_comb begin
    flags_d = flags_q;
    if (we_i) flags_d = {carry_i, zero_i};
  end

  // Reset wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (rst) flags_q <= 2'b00;
    else     flags_q <= flags_d;
  end

  assign carry_o = flags_q[1];
  assign zero_o  = flags_q[0];

endmodule

// File: rtl/alu.sv
// Combinational 8-op ALU with a registered carry/zero status copy.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flag_we,
  output logic [WIDTH-1:0]    out,
  output logic                carry,
  output logic                zero,
  output logic                flag_carry,
  output logic                flag_zero
);

  logic [WIDTH:0] sum_w;
  logic [WIDTH:0] diff_w;

  assign sum_w  = {1'b0, a} + {1'b0, b};
  // Top bit of the extended difference is the unsigned borrow.
  assign diff_w = {1'b0, a} - {1'b0, b};

  always_comb begin
    out   = '0;
    carry = 1'b0;
    case (opcode)
      OP_ADD: begin
        out   = sum_w[WIDTH-1:0];
        carry = sum_w[WIDTH];
      end
      OP_SUB: begin
        out   = diff_w[WIDTH-1:0];
        carry = diff_w[WIDTH];
      end
      OP_AND: out = a & b;
      OP_OR:  out = a | b;
      OP_XOR: out = a ^ b;
      OP_NOT: out = ~a;
      OP_SHL: begin
        out   = {a[WIDTH-2:0], 1'b0};
        carry = a[WIDTH-1];
      end
      OP_SHR: begin
        out   = {1'b0, a[WIDTH-1:1]};
        carry = a[0];
      end
      default: begin
        out   = '0;
        carry = 1'b0;
      end
    endcase
  end

  assign zero = (out == '0);

  alu_flags_reg u_flags (
    .clk     (clk),
    .rst     (rst),
    .we_i    (flag_we),
    .carry_i (carry),
    .zero_i  (zero),
    .carry_o (flag_carry),
    .zero_o  (flag_zero)
  );

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: vector table, sweeps, random, flags.
module tb_alu;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b;
  logic [2:0] opcode;
  logic       flag_we;
  logic [7:0] out;
  logic       carry, zero;
  logic       flag_carry, flag_zero;

  int errs = 0;
  int checks = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] eo;
    logic       ec;
    logic       ez;
  } vec_t;

  vec_t tbl[$];
  logic [9:0] exp_q[$];

  alu #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .opcode     (opcode),
    .flag_we    (flag_we),
    .out        (out),
    .carry      (carry),
    .zero       (zero),
    .flag_carry (flag_carry),
    .flag_zero  (flag_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [9:0] act,
                     input logic [9:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // Independent arithmetic reference: returns {out, carry, zero}.
  function automatic logic [9:0] model(input logic [2:0] op,
                                       input logic [7:0] av,
                                       input logic [7:0] bv);
    int x, y, r, c;
    x = int'(av);
    y = int'(bv);
    r = 0;
    c = 0;
    case (op)
      3'd0: begin r = (x + y) % 256; c = (x + y > 255) ? 1 : 0; end
      3'd1: begin r = (x - y + 256) % 256; c = (x < y) ? 1 : 0; end
      3'd2: r = int'(av & bv);
      3'd3: r = int'(av | bv);
      3'd4: r = int'(av ^ bv);
      3'd5: r = 255 - x;
      3'd6: begin r = (x * 2) % 256; c = x / 128; end
      default: begin r = x / 2; c = x % 2; end
    endcase
    return {r[7:0], c[0], (r == 0)};
  endfunction

  task automatic drive(input logic [2:0] op, input logic [7:0] av,
                       input logic [7:0] bv, input logic [9:0] e);
    opcode = op;
    a = av;
    b = bv;
    exp_q.push_back(e);
  endtask

  task automatic collect(input string nm);
    logic [9:0] e;
    #1;
    if (exp_q.size() == 0) begin
      chk({nm, "_queue_empty"}, 10'h0, 10'h3ff);
    end else begin
      e = exp_q.pop_front();
      chk(nm, {out, carry, zero}, e);
      if ($isunknown({out, carry, zero, flag_carry, flag_zero}))
        chk({nm, "_x"}, 10'h3ff, 10'h0);
    end
  endtask

  task automatic run(input string nm, input logic [2:0] op,
                     input logic [7:0] av, input logic [7:0] bv);
    drive(op, av, bv, model(op, av, bv));
    collect(nm);
  endtask

  initial begin
    rst = 1'b1;
    flag_we = 1'b0;
    opcode = OP_ADD;
    a = 8'h03;
    b = 8'h04;

    // Reset: flags clear while the datapath keeps tracking inputs.
    @(posedge clk);
    #1;
    chk("rst_flags", {8'h0, flag_carry, flag_zero}, 10'h0);
    drive(OP_ADD, 8'h03, 8'h04, {8'h07, 1'b0, 1'b0});
    collect("rst_comb");
    rst = 1'b0;

    tbl.push_back('{OP_ADD, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0});
    tbl.push_back('{OP_ADD, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1});
    tbl.push_back('{OP_ADD, 8'h40, 8'h80, 8'hC0, 1'b0, 1'b0});
    tbl.push_back('{OP_SUB, 8'h01, 8'h01, 8'h00, 1'b0, 1'b1});
    tbl.push_back('{OP_SUB, 8'h01, 8'h80, 8'h81, 1'b1, 1'b0});
    tbl.push_back('{OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0});
    tbl.push_back('{OP_AND, 8'h33, 8'hCC, 8'h00, 1'b0, 1'b1});
    tbl.push_back('{OP_OR,  8'h11, 8'h33, 8'h33, 1'b0, 1'b0});
    tbl.push_back('{OP_XOR, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1});
    tbl.push_back('{OP_NOT, 8'hFF, 8'h5A, 8'h00, 1'b0, 1'b1});
    tbl.push_back('{OP_SHL, 8'h88, 8'hFF, 8'h10, 1'b1, 1'b0});
    tbl.push_back('{OP_SHR, 8'h11, 8'hFF, 8'h08, 1'b1, 1'b0});
    tbl.push_back('{OP_NOT, 8'h0F, 8'h00, 8'hF0, 1'b0, 1'b0});
    tbl.push_back('{OP_SHR, 8'h80, 8'h01, 8'h40, 1'b0, 1'b0});

    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].a, tbl[i].b,
            {tbl[i].eo, tbl[i].ec, tbl[i].ez});
      collect($sformatf("tbl%0d", i));
    end

    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        run($sformatf("add_%0d_%0d", i, j), OP_ADD,
            8'(1 << i), 8'(1 << j));
        run($sformatf("sub_%0d_%0d", i, j), OP_SUB,
            8'(1 << i), 8'(1 << j));
      end

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 6; j++) begin
        run($sformatf("and_%0d_%0d", i, j), OP_AND,
            8'(i * 17), 8'(j * 51));
        run($sformatf("or_%0d_%0d", i, j), OP_OR,
            8'(i * 17), 8'(j * 51));
        run($sformatf("xor_%0d_%0d", i, j), OP_XOR,
            8'(i * 17), 8'(j * 51));
      end

    for (int i = 0; i < 16; i++) begin
      run($sformatf("not_%0d", i), OP_NOT, 8'(i * 17),
          8'($urandom_range(0, 255)));
      run($sformatf("shl_%0d", i), OP_SHL, 8'(i * 17),
          8'($urandom_range(0, 255)));
      run($sformatf("shr_%0d", i), OP_SHR, 8'(i * 17),
          8'($urandom_range(0, 255)));
    end

    for (int i = 0; i < 1000; i++)
      run($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)),
          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

    // Flag register sequence.
    @(posedge clk);
    #1;
    opcode = OP_ADD;
    a = 8'h80;
    b = 8'h80;
    flag_we = 1'b1;
    @(posedge clk);
    #1;
    chk("flag_write", {8'h0, flag_carry, flag_zero}, {8'h0, 2'b11});

    flag_we = 1'b0;
    a = 8'h01;
    b = 8'h01;
    @(posedge clk);
    #1;
    chk("flag_hold", {8'h0, flag_carry, flag_zero}, {8'h0, 2'b11});

    rst = 1'b1;
    flag_we = 1'b1;
    a = 8'h80;
    b = 8'h80;
    @(posedge clk);
    #1;
    chk("flag_rst_prio", {8'h0, flag_carry, flag_zero}, 10'h0);

    rst = 1'b0;
    opcode = OP_SUB;
    a = 8'h01;
    b = 8'h02;
    @(posedge clk);
    #1;
    chk("flag_borrow", {8'h0, flag_carry, flag_zero}, {8'h0, 2'b10});

    flag_we = 1'b0;
    opcode = OP_XOR;
    a = 8'h5A;
    b = 8'h5A;
    @(posedge clk);
    #1;
    chk("flag_hold2", {8'h0, flag_carry, flag_zero}, {8'h0, 2'b10});

    flag_we = 1'b1;
    @(posedge clk);
    #1;
    chk("flag_zero_only", {8'h0, flag_carry, flag_zero}, {8'h0, 2'b01});

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
